// File: rtl/engine_chain_matcher_if.sv
// Byte-stream bus between the shared char decoder and one chain-matcher engine.
interface engine_chain_matcher_if #(
    parameter int N_STATES = 8,
    parameter int OFFSET_W = 16,
    parameter int CNT_W    = 8
);
    logic                sod;
    logic                en;
    logic [N_STATES-1:0] in_char;
    logic                in_brk;
    logic                out;
    logic                match_pulse;
    logic [OFFSET_W-1:0] match_offset;
    logic [CNT_W-1:0]    match_cnt;

    modport master (
        output sod, en, in_char, in_brk,
        input  out, match_pulse, match_offset, match_cnt
    );

    modport slave (
        input  sod, en, in_char, in_brk,
        output out, match_pulse, match_offset, match_cnt
    );
endinterface

// File: rtl/engine_chain_matcher.sv
// N-stage literal/char-class chain matcher with optional per-stage [^brk]* gaps and anchoring.
// The saturating match counter is built only when ENGINE_MATCH_CNT_EN is defined.
module engine_chain_matcher #(
    parameter int                  N_STATES = 8,
    parameter logic [N_STATES-1:0] GAP_MASK = '0,
    parameter bit                  ANCHORED = 1'b0,
    parameter int                  OFFSET_W = 16,
    parameter int                  CNT_W    = 8
) (
    input logic                   clk,
    engine_chain_matcher_if.slave bus
);
    // s_q[j] holds stage j+1; the top bit is the completion register and doubles as the pulse.
    logic [N_STATES-1:0] s_q;
    logic [N_STATES-1:0] s_d;
    logic                start;
    logic                hit;
    logic                out_q;
    logic [OFFSET_W-1:0] byte_cnt_q;
    logic [OFFSET_W-1:0] offset_q;

    if (ANCHORED) begin : g_anchor
        logic first_q;
        always_ff @(posedge clk) begin
            if (bus.sod) begin
                first_q <= 1'b1;
            end else if (bus.en) begin
                first_q <= 1'b0;
            end
        end
        assign start = first_q;
    end else begin : g_free
        assign start = 1'b1;
    end

    always_comb begin
        logic prev;
        prev = start;
        s_d  = '0;
        for (int j = 0; j < N_STATES; j++) begin
            s_d[j] = prev & bus.in_char[j];
            // The last stage never self-loops: it only records a completion.
            if (j < N_STATES - 1) begin
                s_d[j] = s_d[j] | (GAP_MASK[j] & s_q[j] & ~bus.in_brk);
            end
            prev = s_q[j];
        end
    end

    assign hit = bus.en & s_d[N_STATES-1];

    always_ff @(posedge clk) begin
        if (bus.sod) begin
            s_q        <= '0;
            byte_cnt_q <= '0;
            out_q      <= 1'b0;
            offset_q   <= '0;
        end else if (bus.en) begin
            s_q <= s_d;
            if (byte_cnt_q != '1) begin
                byte_cnt_q <= byte_cnt_q + OFFSET_W'(1);
            end
            if (hit && !out_q) begin
                offset_q <= byte_cnt_q;
            end
            if (hit) begin
                out_q <= 1'b1;
            end
        end else begin
            // Idle byte: intermediate stages hold, but the completion pulse must drop.
            s_q[N_STATES-1] <= 1'b0;
        end
    end

    assign bus.out          = out_q;
    assign bus.match_pulse  = s_q[N_STATES-1];
    assign bus.match_offset = offset_q;

`ifdef ENGINE_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (bus.sod) begin
            cnt_q <= '0;
        end else if (hit && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_engine_chain_matcher.sv
// Bench for engine_chain_matcher: four configurations driven in lockstep, checked against a
// position-based regex model (which byte positions can each stage be matched at).
module tb_engine_chain_matcher;
    localparam int N    = 4;
    localparam int OW   = 16;
    localparam int NDUT = 4;
    localparam int HMAX = 64;
`ifdef ENGINE_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         sod_s  = 1'b1;
    logic         en_s   = 1'b0;
    int           code_s = 4;
    logic [N-1:0] char_v;
    logic         brk_v;

    always_comb begin
        char_v = '0;
        if (code_s >= 0 && code_s < N) char_v[code_s] = 1'b1;
        brk_v = (code_s == 5);
    end

    engine_chain_matcher_if #(.N_STATES(N), .OFFSET_W(OW), .CNT_W(8)) b0 ();
    engine_chain_matcher_if #(.N_STATES(N), .OFFSET_W(OW), .CNT_W(8)) b1 ();
    engine_chain_matcher_if #(.N_STATES(N), .OFFSET_W(OW), .CNT_W(8)) b2 ();
    engine_chain_matcher_if #(.N_STATES(N), .OFFSET_W(OW), .CNT_W(2)) b3 ();

    assign b0.sod = sod_s; assign b0.en = en_s; assign b0.in_char = char_v; assign b0.in_brk = brk_v;
    assign b1.sod = sod_s; assign b1.en = en_s; assign b1.in_char = char_v; assign b1.in_brk = brk_v;
    assign b2.sod = sod_s; assign b2.en = en_s; assign b2.in_char = char_v; assign b2.in_brk = brk_v;
    assign b3.sod = sod_s; assign b3.en = en_s; assign b3.in_char = char_v; assign b3.in_brk = brk_v;

    engine_chain_matcher #(.N_STATES(N), .GAP_MASK(4'b0000), .ANCHORED(1'b0), .OFFSET_W(OW), .CNT_W(8))
        dut0 (.clk(clk), .bus(b0));
    engine_chain_matcher #(.N_STATES(N), .GAP_MASK(4'b0010), .ANCHORED(1'b0), .OFFSET_W(OW), .CNT_W(8))
        dut1 (.clk(clk), .bus(b1));
    engine_chain_matcher #(.N_STATES(N), .GAP_MASK(4'b0000), .ANCHORED(1'b1), .OFFSET_W(OW), .CNT_W(8))
        dut2 (.clk(clk), .bus(b2));
    engine_chain_matcher #(.N_STATES(N), .GAP_MASK(4'b0101), .ANCHORED(1'b0), .OFFSET_W(OW), .CNT_W(2))
        dut3 (.clk(clk), .bus(b3));

    // Packed view {out, match_pulse, match_offset, match_cnt} per engine
    logic [25:0] obs_vec [NDUT];
    assign obs_vec[0] = {b0.out, b0.match_pulse, b0.match_offset, b0.match_cnt};
    assign obs_vec[1] = {b1.out, b1.match_pulse, b1.match_offset, b1.match_cnt};
    assign obs_vec[2] = {b2.out, b2.match_pulse, b2.match_offset, b2.match_cnt};
    assign obs_vec[3] = {b3.out, b3.match_pulse, b3.match_offset, 6'b0, b3.match_cnt};

    // Per-engine configuration as seen by the model
    int gap_cfg  [NDUT] = '{0, 2, 0, 5};
    bit anch_cfg [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cmax_cfg [NDUT] = '{255, 255, 255, 3};

    // Model state: bytes accepted since sod, and expected outputs
    int hist [HMAX];
    int hlen = 0;
    bit exp_out   [NDUT];
    bit exp_pulse [NDUT];
    int exp_off   [NDUT];
    int exp_cnt   [NDUT];

    int total = 0;
    int bad   = 0;

    function automatic int code_of(byte c);
        case (c)
            "a": return 0;
            "b": return 1;
            "c": return 2;
            "d": return 3;
            "n": return 5;
            default: return 4;
        endcase
    endfunction

    // Does pattern k complete exactly at byte position q? Stage s can sit at position p if its
    // class matches there and the previous stage sits directly before it, or (gap stage) anywhere
    // earlier with no break byte strictly in between.
    function automatic bit completes(int k, int q);
        bit reach [N][HMAX];
        for (int s = 0; s < N; s++)
            for (int p = 0; p < HMAX; p++) reach[s][p] = 1'b0;
        for (int p = 0; p <= q; p++)
            reach[0][p] = (hist[p] == 0) && (!anch_cfg[k] || p == 0);
        for (int s = 1; s < N; s++) begin
            for (int p2 = 0; p2 <= q; p2++) begin
                if (hist[p2] != s) continue;
                for (int p1 = 0; p1 < p2; p1++) begin
                    if (!reach[s-1][p1]) continue;
                    if (p2 == p1 + 1) begin
                        reach[s][p2] = 1'b1;
                    end else if (((gap_cfg[k] >> (s - 1)) & 1) != 0) begin
                        bit clean = 1'b1;
                        for (int m = p1 + 1; m < p2; m++) if (hist[m] == 5) clean = 1'b0;
                        if (clean) reach[s][p2] = 1'b1;
                    end
                end
            end
        end
        return reach[N-1][q];
    endfunction

    function automatic logic [25:0] expv(int k);
        logic [15:0] o = exp_off[k][15:0];
        logic [7:0]  c = exp_cnt[k][7:0];
        return {exp_out[k], exp_pulse[k], o, c};
    endfunction

    // Apply one byte cycle, then advance the model to match the post-edge outputs.
    task automatic step(input bit s, input bit e, input int c);
        sod_s  = s;
        en_s   = e;
        code_s = c;
        @(posedge clk);
        #1;
        if (s) begin
            hlen = 0;
            for (int k = 0; k < NDUT; k++) begin
                exp_out[k] = 0; exp_pulse[k] = 0; exp_off[k] = 0; exp_cnt[k] = 0;
            end
        end else if (e) begin
            int q = hlen;
            hist[q] = c;
            hlen++;
            for (int k = 0; k < NDUT; k++) begin
                bit h = completes(k, q);
                exp_pulse[k] = h;
                if (h) begin
                    if (!exp_out[k]) begin
                        exp_out[k] = 1'b1;
                        exp_off[k] = q;
                    end
                    if (CNT_EN && exp_cnt[k] < cmax_cfg[k]) exp_cnt[k]++;
                end
            end
        end else begin
            for (int k = 0; k < NDUT; k++) exp_pulse[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        step(1, 1, 0);
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec[k] !== 26'h0) begin
                bad++;
                $display("FAIL reset dut%0d: got %h want %h", k, obs_vec[k], 26'h0);
            end
        end
    endtask

    task automatic test_basic();
        string str = "abcd";
        step(1, 0, 4);
        for (int i = 0; i < str.len(); i++) begin
            step(0, 1, code_of(str[i]));
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (obs_vec[k] !== expv(k)) begin
                    bad++;
                    $display("FAIL basic dut%0d byte%0d: got %h want %h", k, i, obs_vec[k], expv(k));
                end
            end
        end
        total++;
        if (b0.out !== 1'b1 || b0.match_pulse !== 1'b1 || b0.match_offset !== 16'd3) begin
            bad++;
            $display("FAIL basic_abcd: got out=%0b pulse=%0b off=%0d want 1 1 3",
                     b0.out, b0.match_pulse, b0.match_offset);
        end
        step(0, 0, 4);
        total++;
        if (b0.out !== 1'b1 || b0.match_pulse !== 1'b0) begin
            bad++;
            $display("FAIL basic_hold: got out=%0b pulse=%0b want 1 0", b0.out, b0.match_pulse);
        end
    endtask

    task automatic test_gap();
        string seqs [2] = '{"abxycd", "abncd"};
        for (int t = 0; t < 2; t++) begin
            step(1, 0, 4);
            for (int i = 0; i < seqs[t].len(); i++) begin
                step(0, 1, code_of(seqs[t][i]));
                for (int k = 0; k < NDUT; k++) begin
                    total++;
                    if (obs_vec[k] !== expv(k)) begin
                        bad++;
                        $display("FAIL gap%0d dut%0d byte%0d: got %h want %h", t, k, i, obs_vec[k], expv(k));
                    end
                end
            end
        end
        total++;
        if (b1.out !== 1'b0) begin
            bad++;
            $display("FAIL gap_brk: got out=%0b want 0", b1.out);
        end
        step(1, 0, 4);
        for (int i = 0; i < 6; i++) step(0, 1, code_of(seqs[0][i]));
        total++;
        if (b1.out !== 1'b1 || b1.match_offset !== 16'd5 || b0.out !== 1'b0) begin
            bad++;
            $display("FAIL gap_span: got out=%0b off=%0d nogap_out=%0b want 1 5 0",
                     b1.out, b1.match_offset, b0.out);
        end
    endtask

    task automatic test_anchor();
        string str = "xabcd";
        step(1, 0, 4);
        for (int i = 0; i < str.len(); i++) begin
            step(0, 1, code_of(str[i]));
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (obs_vec[k] !== expv(k)) begin
                    bad++;
                    $display("FAIL anchor dut%0d byte%0d: got %h want %h", k, i, obs_vec[k], expv(k));
                end
            end
        end
        total++;
        if (b2.out !== 1'b0 || b0.out !== 1'b1 || b0.match_offset !== 16'd4) begin
            bad++;
            $display("FAIL anchor_late: got anch_out=%0b out=%0b off=%0d want 0 1 4",
                     b2.out, b0.out, b0.match_offset);
        end
        step(1, 0, 4);
        for (int i = 1; i < 5; i++) step(0, 1, code_of(str[i]));
        total++;
        if (b2.out !== 1'b1 || b2.match_offset !== 16'd3) begin
            bad++;
            $display("FAIL anchor_first: got out=%0b off=%0d want 1 3", b2.out, b2.match_offset);
        end
    endtask

    task automatic test_en_sod();
        step(1, 0, 4);
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4);
        for (int i = 1; i < 4; i++) step(0, 1, i);
        total++;
        if (b0.out !== 1'b1 || b0.match_offset !== 16'd3) begin
            bad++;
            $display("FAIL en_gaps: got out=%0b off=%0d want 1 3", b0.out, b0.match_offset);
        end
        step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
        step(1, 0, 4);
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec[k] !== 26'h0) begin
                bad++;
                $display("FAIL sod_clear dut%0d: got %h want %h", k, obs_vec[k], 26'h0);
            end
        end
        step(0, 1, 3);
        total++;
        if (b0.out !== 1'b0 || b0.match_pulse !== 1'b0) begin
            bad++;
            $display("FAIL sod_mid: got out=%0b pulse=%0b want 0 0", b0.out, b0.match_pulse);
        end
        step(1, 1, 0);
        for (int i = 1; i < 4; i++) step(0, 1, i);
        for (int k = 0; k < NDUT; k++) begin
            total++;
            if (obs_vec[k] !== expv(k) || obs_vec[k][25] !== 1'b0) begin
                bad++;
                $display("FAIL sod_discard dut%0d: got %h want %h", k, obs_vec[k], expv(k));
            end
        end
    endtask

    task automatic test_count();
        string str = "abcdabcd";
        step(1, 0, 4);
        for (int i = 0; i < str.len(); i++) step(0, 1, code_of(str[i]));
        total++;
        if (b0.match_cnt !== (CNT_EN ? 8'd2 : 8'd0) || b0.match_offset !== 16'd3) begin
            bad++;
            $display("FAIL count_two: got cnt=%0d off=%0d want %0d 3",
                     b0.match_cnt, b0.match_offset, CNT_EN ? 2 : 0);
        end
        step(1, 0, 4);
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 4; i++) step(0, 1, i);
        total++;
        if (b3.match_cnt !== (CNT_EN ? 2'd3 : 2'd0) || b0.match_cnt !== (CNT_EN ? 8'd5 : 8'd0)) begin
            bad++;
            $display("FAIL count_sat: got cnt2=%0d cnt8=%0d want %0d %0d",
                     b3.match_cnt, b0.match_cnt, CNT_EN ? 3 : 0, CNT_EN ? 5 : 0);
        end
    endtask

    task automatic test_back_to_back();
        string str = "abcddd";
        step(1, 0, 4);
        for (int i = 0; i < str.len(); i++) begin
            step(0, 1, code_of(str[i]));
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (obs_vec[k] !== expv(k)) begin
                    bad++;
                    $display("FAIL b2b dut%0d byte%0d: got %h want %h", k, i, obs_vec[k], expv(k));
                end
            end
            if (i >= 3) begin
                total++;
                if (b3.match_pulse !== 1'b1 || b0.match_pulse !== (i == 3)) begin
                    bad++;
                    $display("FAIL b2b_pulse byte%0d: got gap=%0b plain=%0b want 1 %0b",
                             i, b3.match_pulse, b0.match_pulse, i == 3);
                end
            end
        end
        total++;
        if (b3.match_offset !== 16'd3 || b3.match_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
            bad++;
            $display("FAIL b2b_first: got off=%0d cnt=%0d want 3 %0d",
                     b3.match_offset, b3.match_cnt, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_random();
        int cursor = 0;
        step(1, 0, 4);
        for (int n = 0; n < 600; n++) begin
            bit s;
            bit e;
            int c;
            s = (hlen >= HMAX - 4) || ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) < 6) c = cursor;
            else c = int'($urandom_range(0, 5));
            if (e) cursor = (c < 4) ? (c + 1) % 4 : 0;
            if (s) cursor = 0;
            step(s, e, c);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if (obs_vec[k] !== expv(k)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", k, n, obs_vec[k], expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_anchor();
        test_en_sod();
        test_count();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
